// File: rtl/nx_node_instr_store.sv
// ---------------------------------------------------------------------------
// nx_node_instr_store
//
// Owns the single-port instruction RAM that sits upstream of nx_node_core.
// Instruction words from the message decoder are appended at a write pointer.
// Fetches from the core are arbitrated against those loads, so that the RAM
// sees at most one access per cycle. Loads win by default. A fetch that has
// lost too many cycles in a row is then force-granted. Fetched words are
// registered and held until the next accepted fetch returns. The write
// pointer doubles as the populated-instruction count for the core.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_clear             pulse: discard program (pointer, count, overflow -> 0)
//   i_load_valid/data   instruction word offered for append
//   o_load_ready        load accepted this cycle (valid && ready)
//   o_load_overflow     sticky: load offered while RAM full
//   i_instr_addr/rd_en  core fetch request
//   o_instr_rd_data     fetched word, held between returning reads
//   o_instr_stall       fetch not accepted this cycle
//   o_populated         instructions loaded (zero-extended/truncated count)
//   o_ram_*             RAM command interface (address, write, read strobe)
//   i_ram_rd_data       RAM read data, valid 1 cycle after o_ram_rd_en
// ---------------------------------------------------------------------------
module nx_node_instr_store #(
    parameter int RAM_ADDR_W       = 10,
    parameter int RAM_DATA_W       = 32,
    parameter int STARVE_LIMIT     = 4,
    parameter int NODE_PARAM_WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_clear,
    input  logic                        i_load_valid,
    input  logic [RAM_DATA_W-1:0]       i_load_data,
    output logic                        o_load_ready,
    output logic                        o_load_overflow,
    input  logic [RAM_ADDR_W-1:0]       i_instr_addr,
    input  logic                        i_instr_rd_en,
    output logic [RAM_DATA_W-1:0]       o_instr_rd_data,
    output logic                        o_instr_stall,
    output logic [NODE_PARAM_WIDTH-1:0] o_populated,
    output logic [RAM_ADDR_W-1:0]       o_ram_addr,
    output logic                        o_ram_wr_en,
    output logic [RAM_DATA_W-1:0]       o_ram_wr_data,
    output logic                        o_ram_rd_en,
    input  logic [RAM_DATA_W-1:0]       i_ram_rd_data
);

    // The pointer is one bit wider than the address so that a completely
    // full RAM (2^RAM_ADDR_W words) can be told apart from an empty one.
    localparam int PTR_W = RAM_ADDR_W + 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {RAM_ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic                  r_overflow;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic                  r_rd_pending;
    logic [RAM_DATA_W-1:0] r_rd_data;

    logic w_full;
    logic w_starve_ok;
    logic w_load_go;
    logic w_fetch_go;

    // Arbitration. A load yields only to a fetch that has already been
    // stalled STARVE_LIMIT cycles in a row. A clear blocks loads in its own
    // cycle, so that no word lands in the program that is being discarded.
    always_comb begin
        w_full      = (r_wr_ptr == DEPTH);
        w_starve_ok = (r_starve_cnt < LIMIT);
        w_load_go   = i_load_valid && !w_full && !i_clear &&
                      (!i_instr_rd_en || w_starve_ok);
        w_fetch_go  = i_instr_rd_en && !w_load_go;
    end

    // RAM command mux. The write-data bus is zeroed when no load is
    // granted, so that a stale word is never presented to the RAM.
    always_comb begin
        o_ram_wr_en   = w_load_go;
        o_ram_rd_en   = w_fetch_go;
        o_ram_wr_data = w_load_go ? i_load_data : '0;
        o_ram_addr    = w_load_go ? r_wr_ptr[RAM_ADDR_W-1:0] : i_instr_addr;
        o_load_ready  = w_load_go;
        o_instr_stall = i_instr_rd_en && !w_fetch_go;
    end

    // Write pointer and sticky overflow flag. A clear has priority over a
    // same-cycle overflow attempt, so that the flag always comes back to 0
    // after a clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load_go) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_load_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Starvation counter. It counts consecutive stalled-fetch cycles and
    // saturates at the limit. Any gap in the request, or a granted fetch,
    // restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
        end else if (!i_instr_rd_en || w_fetch_go) begin
            r_starve_cnt <= '0;
        end else if (w_starve_ok) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    // Read return path. The RAM answers one cycle after the strobe. The
    // word is captured a cycle later and then held, so that the core sees
    // stable data between fetches. Reset drops any read still in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_pending <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_rd_pending <= w_fetch_go;
            if (r_rd_pending) begin
                r_rd_data <= i_ram_rd_data;
            end
        end
    end

    assign o_instr_rd_data = r_rd_data;
    assign o_load_overflow = r_overflow;

    // The populated count is presented at the node-parameter width. It is
    // zero-extended when that width is wider than the pointer, and
    // truncated when it is narrower.
    generate
        if (NODE_PARAM_WIDTH > PTR_W) begin : g_pop_ext
            assign o_populated = {{(NODE_PARAM_WIDTH - PTR_W){1'b0}}, r_wr_ptr};
        end else begin : g_pop_trunc
            assign o_populated = r_wr_ptr[NODE_PARAM_WIDTH-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_nx_node_instr_store.sv
// ---------------------------------------------------------------------------
// tb_nx_node_instr_store
//
// Drives nx_node_instr_store with directed scenarios and then random
// traffic. An eight-entry RAM model hangs off the DUT's RAM port. A
// behavioural reference tracks the program pointer, overflow flag,
// starvation age, memory contents and the two-cycle fetch return.
// ---------------------------------------------------------------------------
module tb_nx_node_instr_store;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
    localparam int NPW   = 8;
    localparam int DEPTH = 1 << AW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clr = 1'b0;
    logic           loadValid = 1'b0;
    logic [DW-1:0]  loadData = '0;
    logic           loadReady;
    logic           loadOverflow;
    logic [AW-1:0]  instrAddr = '0;
    logic           instrRdEn = 1'b0;
    logic [DW-1:0]  instrRdData;
    logic           instrStall;
    logic [NPW-1:0] populated;
    logic [AW-1:0]  ramAddr;
    logic           ramWrEn;
    logic [DW-1:0]  ramWrData;
    logic           ramRdEn;
    logic [DW-1:0]  ramRdData = '0;

    int passCount  = 0;
    int checkCount = 0;

    // Reference state: program length, sticky flag, consecutive losses of
    // the current fetch, memory image and the data travelling back to the core.
    int            mPtr;
    bit            mOvf;
    int            mStarve;
    logic [DW-1:0] mMem [DEPTH];
    bit            mRetValid;
    logic [DW-1:0] mRetData;
    logic [DW-1:0] mRd;
    bit            mLoadGo;
    bit            mFetchGo;

    logic [DW-1:0] ram [DEPTH];

    nx_node_instr_store #(
        .RAM_ADDR_W      (AW),
        .RAM_DATA_W      (DW),
        .STARVE_LIMIT    (LIMIT),
        .NODE_PARAM_WIDTH(NPW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_clear        (clr),
        .i_load_valid   (loadValid),
        .i_load_data    (loadData),
        .o_load_ready   (loadReady),
        .o_load_overflow(loadOverflow),
        .i_instr_addr   (instrAddr),
        .i_instr_rd_en  (instrRdEn),
        .o_instr_rd_data(instrRdData),
        .o_instr_stall  (instrStall),
        .o_populated    (populated),
        .o_ram_addr     (ramAddr),
        .o_ram_wr_en    (ramWrEn),
        .o_ram_wr_data  (ramWrData),
        .o_ram_rd_en    (ramRdEn),
        .i_ram_rd_data  (ramRdData)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Single-port RAM with a one-cycle read latency.
    always @(posedge clk) begin
        if (ramWrEn) ram[ramAddr] <= ramWrData;
        if (ramRdEn) ramRdData <= ram[ramAddr];
    end

    // Reference reset: memory survives, all control state returns to zero.
    task automatic modelReset();
        mPtr      = 0;
        mOvf      = 0;
        mStarve   = 0;
        mRetValid = 0;
        mRetData  = '0;
        mRd       = '0;
    endtask

    // Decides who owns the RAM this cycle from the currently driven inputs.
    task automatic modelEval();
        bit full;
        full     = (mPtr == DEPTH);
        mLoadGo  = loadValid && !full && !clr && (!instrRdEn || mStarve < LIMIT);
        mFetchGo = instrRdEn && !mLoadGo;
    endtask

    // Advances DUT and reference by one clock. Afterwards the inputs can be
    // changed safely at the falling edge.
    task automatic tick();
        bit full;
        modelEval();
        full = (mPtr == DEPTH);
        @(posedge clk);
        if (mRetValid) mRd = mRetData;
        mRetValid = mFetchGo;
        mRetData  = mMem[instrAddr];
        if (mLoadGo) begin
            mMem[mPtr] = loadData;
            mPtr++;
        end
        if (clr) begin
            mPtr = 0;
            mOvf = 0;
        end else if (loadValid && full) begin
            mOvf = 1;
        end
        if (!instrRdEn || mFetchGo) mStarve = 0;
        else if (mStarve < LIMIT) mStarve++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        checkCount++;
        if ({loadReady, instrStall, loadOverflow} !== 3'b000 || populated !== '0 || instrRdData !== '0)
            $display("[TB] FAIL reset_outputs: ready=%b stall=%b ovf=%b pop=%0d rd=%h required all 0",
                     loadReady, instrStall, loadOverflow, populated, instrRdData);
        else passCount++;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_load_three();
        for (int i = 0; i < 3; i++) begin
            loadValid = 1'b1;
            loadData  = 32'hA0 + i;
            #1;
            checkCount++;
            if (loadReady !== 1'b1 || ramWrEn !== 1'b1 || ramAddr !== AW'(i) || ramWrData !== loadData)
                $display("[TB] FAIL load_write%0d: ready=%b wr=%b addr=%0d data=%h required 1 1 %0d %h",
                         i, loadReady, ramWrEn, ramAddr, ramWrData, i, loadData);
            else passCount++;
            checkCount++;
            if (populated !== NPW'(i))
                $display("[TB] FAIL load_pop_before%0d: pop=%0d required %0d", i, populated, i);
            else passCount++;
            tick();
        end
        loadValid = 1'b0;
        #1;
        checkCount++;
        if (populated !== NPW'(3))
            $display("[TB] FAIL load_pop_final: pop=%0d required 3", populated);
        else passCount++;
    endtask

    task automatic test_fetch();
        instrRdEn = 1'b1;
        instrAddr = AW'(1);
        #1;
        checkCount++;
        if (instrStall !== 1'b0 || ramRdEn !== 1'b1 || ramAddr !== AW'(1))
            $display("[TB] FAIL fetch_issue: stall=%b rd_en=%b addr=%0d required 0 1 1",
                     instrStall, ramRdEn, ramAddr);
        else passCount++;
        tick();
        instrRdEn = 1'b0;
        tick();
        #1;
        checkCount++;
        if (instrRdData !== 32'hA1)
            $display("[TB] FAIL fetch_data: rd=%h required a1", instrRdData);
        else passCount++;
        tick();
        tick();
        #1;
        checkCount++;
        if (instrRdData !== 32'hA1)
            $display("[TB] FAIL fetch_hold: rd=%h required a1", instrRdData);
        else passCount++;
    endtask

    task automatic test_starvation();
        int grantAt;
        int stalls;
        grantAt   = -1;
        stalls    = 0;
        loadValid = 1'b1;
        instrRdEn = 1'b1;
        instrAddr = AW'(0);
        for (int c = 0; c < 10 && grantAt < 0; c++) begin
            loadData = 32'hB0 + c;
            #1;
            if (instrStall) stalls++;
            else begin
                grantAt = c;
                checkCount++;
                if (loadReady !== 1'b0 || ramRdEn !== 1'b1)
                    $display("[TB] FAIL starve_grant_excl: ready=%b rd_en=%b required 0 1",
                             loadReady, ramRdEn);
                else passCount++;
            end
            tick();
        end
        checkCount++;
        if (grantAt != LIMIT || stalls != LIMIT)
            $display("[TB] FAIL starve_count: grant cycle=%0d stalls=%0d required %0d %0d",
                     grantAt, stalls, LIMIT, LIMIT);
        else passCount++;
        instrRdEn = 1'b0;
        loadData  = 32'hC7;
        #1;
        checkCount++;
        if (loadReady !== 1'b1 || ramAddr !== AW'(7))
            $display("[TB] FAIL starve_resume: ready=%b addr=%0d required 1 7", loadReady, ramAddr);
        else passCount++;
        tick();
        loadValid = 1'b0;
    endtask

    task automatic test_full_overflow();
        #1;
        checkCount++;
        if (populated !== NPW'(DEPTH) || loadOverflow !== 1'b0)
            $display("[TB] FAIL full_pop: pop=%0d ovf=%b required %0d 0", populated, loadOverflow, DEPTH);
        else passCount++;
        loadValid = 1'b1;
        loadData  = 32'hDEAD;
        #1;
        checkCount++;
        if (loadReady !== 1'b0 || ramWrEn !== 1'b0)
            $display("[TB] FAIL full_reject: ready=%b wr=%b required 0 0", loadReady, ramWrEn);
        else passCount++;
        tick();
        loadValid = 1'b0;
        #1;
        checkCount++;
        if (loadOverflow !== 1'b1 || populated !== NPW'(DEPTH))
            $display("[TB] FAIL full_overflow: ovf=%b pop=%0d required 1 %0d", loadOverflow, populated, DEPTH);
        else passCount++;
        tick();
        #1;
        checkCount++;
        if (loadOverflow !== 1'b1)
            $display("[TB] FAIL overflow_sticky: ovf=%b required 1", loadOverflow);
        else passCount++;
    endtask

    task automatic test_clear_with_load();
        clr       = 1'b1;
        loadValid = 1'b1;
        loadData  = 32'h5A5A;
        #1;
        checkCount++;
        if (loadReady !== 1'b0 || ramWrEn !== 1'b0)
            $display("[TB] FAIL clear_blocks_load: ready=%b wr=%b required 0 0", loadReady, ramWrEn);
        else passCount++;
        tick();
        clr = 1'b0;
        #1;
        checkCount++;
        if (populated !== '0 || loadOverflow !== 1'b0)
            $display("[TB] FAIL clear_state: pop=%0d ovf=%b required 0 0", populated, loadOverflow);
        else passCount++;
        checkCount++;
        if (loadReady !== 1'b1 || ramWrEn !== 1'b1 || ramAddr !== AW'(0))
            $display("[TB] FAIL clear_next_load: ready=%b wr=%b addr=%0d required 1 1 0",
                     loadReady, ramWrEn, ramAddr);
        else passCount++;
        tick();
        loadValid = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        instrRdEn = 1'b1;
        instrAddr = AW'(0);
        tick();
        instrRdEn = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkCount++;
        if (instrRdData !== '0 || populated !== '0)
            $display("[TB] FAIL reset_mid_fetch_now: rd=%h pop=%0d required 0 0", instrRdData, populated);
        else passCount++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        tick();
        tick();
        #1;
        checkCount++;
        if (instrRdData !== '0 || populated !== '0)
            $display("[TB] FAIL reset_mid_fetch_after: rd=%h pop=%0d required 0 0", instrRdData, populated);
        else passCount++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            loadValid = ($urandom_range(0, 2) != 0);
            loadData  = $urandom;
            instrRdEn = $urandom_range(0, 1);
            instrAddr = AW'($urandom_range(0, DEPTH - 1));
            clr       = ($urandom_range(0, 15) == 0);
            #1;
            modelEval();
            checkCount++;
            if (loadReady !== mLoadGo || instrStall !== (instrRdEn && !mFetchGo) ||
                ramWrEn !== mLoadGo || ramRdEn !== mFetchGo)
                $display("[TB] FAIL rand_arb c%0d: ready=%b stall=%b wr=%b rd=%b required %b %b %b %b",
                         c, loadReady, instrStall, ramWrEn, ramRdEn,
                         mLoadGo, instrRdEn && !mFetchGo, mLoadGo, mFetchGo);
            else passCount++;
            checkCount++;
            if (populated !== NPW'(mPtr) || loadOverflow !== mOvf || instrRdData !== mRd)
                $display("[TB] FAIL rand_state c%0d: pop=%0d ovf=%b rd=%h required %0d %b %h",
                         c, populated, loadOverflow, instrRdData, mPtr, mOvf, mRd);
            else passCount++;
            tick();
        end
        clr       = 1'b0;
        loadValid = 1'b0;
        instrRdEn = 1'b0;
    endtask

    // Scenario sequence. Each test leaves the inputs idle at a falling edge.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]  = '0;
            mMem[i] = '0;
        end
        modelReset();
        test_reset();
        test_load_three();
        test_fetch();
        test_starvation();
        test_full_overflow();
        test_clear_with_load();
        test_reset_mid_fetch();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/nx_node_instr_store.md
Name: nx_node_instr_store

Overview:
Upstream neighbour of nx_node_core. It owns the single-port instruction RAM.
- Arbitrates between instruction loads arriving from the node's message decoder and instruction fetches from the core.
- Generates the core's fetch stall and holds fetched data stable.
- Maintains the populated-instruction count that drives the core's i_populated.

Parameters:
RAM_ADDR_W, 10, instruction RAM address width
RAM_DATA_W, 32, instruction word width
STARVE_LIMIT, 4, max consecutive cycles a pending fetch may lose to loads before it is force-granted

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_clear  in  1  pulse: discard loaded program (populated count and write pointer to 0)
i_load_valid  in  1  load word offered
i_load_data  in  RAM_DATA_W  instruction word to append
o_load_ready  out  1  load accepted when valid&&ready
o_load_overflow  out  1  sticky: load attempted while RAM full
i_instr_addr  in  RAM_ADDR_W  core fetch address
i_instr_rd_en  in  1  core fetch request
o_instr_rd_data  out  RAM_DATA_W  fetched word, held until next accepted fetch returns
o_instr_stall  out  1  fetch not accepted this cycle
o_populated  out  NODE_PARAM_WIDTH  instructions loaded, zero-extended/truncated from RAM_ADDR_W+1 count
o_ram_addr  out  RAM_ADDR_W  RAM address
o_ram_wr_en  out  1  RAM write strobe
o_ram_wr_data  out  RAM_DATA_W  RAM write data
o_ram_rd_en  out  1  RAM read strobe
i_ram_rd_data  in  RAM_DATA_W  RAM read data, valid exactly 1 cycle after o_ram_rd_en

Behaviour:
Reset:
- All outputs are 0: o_load_ready=0, o_instr_stall=0, o_populated=0, o_instr_rd_data=0, o_load_overflow=0.
- Internal write pointer (RAM_ADDR_W+1 bits) = 0; starvation counter = 0.
- Reset mid-operation discards any in-flight read. o_instr_rd_data returns to 0.

Arbitration (combinational, one RAM access per cycle):
- load_go = i_load_valid && !full && !clear && (!i_instr_rd_en || starve_cnt < STARVE_LIMIT).
- fetch_go = i_instr_rd_en && !load_go.
- o_load_ready = load_go. o_instr_stall = i_instr_rd_en && !fetch_go.
- Loads win by default; a fetch stalled STARVE_LIMIT consecutive cycles is granted on the next cycle.
- starve_cnt increments on each stalled-fetch cycle, clears on fetch_go or when i_instr_rd_en is low, and saturates at STARVE_LIMIT.

Write path:
- On load_go: o_ram_wr_en=1, o_ram_addr=wr_ptr, o_ram_wr_data=i_load_data, then wr_ptr++.
- o_populated tracks wr_ptr, registered and updated the cycle after the write.
- full = (wr_ptr == 2^RAM_ADDR_W). When full, o_load_ready=0.
- A valid load offered while full sets o_load_overflow, which is cleared only by reset or i_clear.

Read path:
- On fetch_go: o_ram_rd_en=1, o_ram_addr=i_instr_addr.
- One cycle later, i_ram_rd_data is captured into o_instr_rd_data (registered). Effective fetch latency is 2 cycles from accept to o_instr_rd_data valid.
- o_instr_rd_data holds its value when there is no returning read.
- Fetch of an address >= wr_ptr is legal and returns RAM contents; no checking is done.

i_clear:
- Blocks loads in its own cycle. Next cycle: wr_ptr=0, o_populated=0, o_load_overflow=0.
- Fetches continue unaffected.

Simultaneous events:
- i_clear with i_load_valid: the load is not accepted.
- Load and fetch in the same cycle: resolved per the arbitration rules above, never both.

Test Plan:
- Load 3 words (0xA0,0xA1,0xA2), no fetches -> RAM writes to addresses 0,1,2 on consecutive cycles; o_populated goes 1,2,3 one cycle after each write.
- Fetch addr 1 with no loads -> o_instr_stall=0, o_ram_rd_en with addr 1, o_instr_rd_data=0xA1 two cycles after request and held afterwards.
- Continuous load_valid plus fetch request, STARVE_LIMIT=4 -> fetch stalled exactly 4 cycles, granted on the 5th (o_load_ready=0 that cycle), then loads resume.
- RAM_ADDR_W=2: load 4 words then a 5th -> o_load_ready=0 on the 5th, o_load_overflow=1, o_populated=4; i_clear -> o_populated=0, overflow=0, next load writes address 0.
- Assert i_rst mid-fetch, with a read issued the cycle before -> o_instr_rd_data=0 immediately and no update afterwards; o_populated=0.
- i_clear coincident with i_load_valid -> no RAM write that cycle; next cycle the load is accepted at address 0.
